next_pc_unit: RTL

NEXT_PC_UNIT -- requirements
Module: next_pc_unit

---
 rtl/next_pc_unit_pkg.sv | 15 +
 rtl/next_pc_unit_if.sv | 33 +++
 rtl/next_pc_unit_ras_stack.sv | 48 ++++
 rtl/next_pc_unit.sv | 106 ++++++++++
 4 files changed

// File: rtl/next_pc_unit_pkg.sv
// Shared definitions for the next-PC unit: EX control-instruction kinds and default widths.
package next_pc_unit_pkg;

    localparam int PC_W_DEF   = 16;
    localparam int DISP_W_DEF = 11;

    // Encoding 3 is reserved and resolves like a not-taken branch.
    typedef enum logic [1:0] {
        KIND_BR   = 2'd0,
        KIND_JREL = 2'd1,
        KIND_JREG = 2'd2,
        KIND_RSVD = 2'd3
    } ex_kind_e;

endpackage

// File: rtl/next_pc_unit_if.sv
// Fetch/execute signal bundle between the pipeline (master) and the next-PC unit (slave).
interface next_pc_unit_if #(
    parameter int PC_W   = 16,
    parameter int DISP_W = 11
);
    logic              stall;
    logic              f_call;
    logic              f_ret;
    logic              ex_valid;
    logic [1:0]        ex_kind;
    logic              ex_taken;
    logic [PC_W-1:0]   ex_pc2;
    logic [PC_W-1:0]   ex_imm;
    logic [DISP_W-1:0] ex_disp;
    logic [PC_W-1:0]   ex_reg;
    logic [PC_W-1:0]   ex_pred;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_plus2;
    logic              flush;
    logic              ras_empty;

    modport master (
        output stall, f_call, f_ret, ex_valid, ex_kind, ex_taken,
               ex_pc2, ex_imm, ex_disp, ex_reg, ex_pred,
        input  pc, pc_plus2, flush, ras_empty
    );

    modport slave (
        input  stall, f_call, f_ret, ex_valid, ex_kind, ex_taken,
               ex_pc2, ex_imm, ex_disp, ex_reg, ex_pred,
        output pc, pc_plus2, flush, ras_empty
    );
endinterface

// File: rtl/next_pc_unit_ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry and keeps the count saturated.
module ras_stack #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_m1;
    logic [PTR_W:0]   count;
    logic [W-1:0]     mem [DEPTH];

    // ptr addresses the next free slot, so the top lives one below it.
    assign ptr_m1 = ptr - PTR_W'(1);
    assign top    = mem[ptr_m1];
    assign empty  = (count == '0);
    assign full   = (count == (PTR_W+1)'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (!full) begin
                count <= count + (PTR_W+1)'(1);
            end
        end else if (pop && !empty) begin
            ptr   <= ptr_m1;
            count <= count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= din;
        end
    end
endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC generator: EX redirect on mispredict, stall hold, optional RAS return prediction.
// Define NEXT_PC_RAS_EN to build with the return-address stack; otherwise calls/returns are ignored.
module next_pc_unit
    import next_pc_unit_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int DISP_W    = DISP_W_DEF,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_PC  = 0
) (
    input logic            clk,
    input logic            rst,
    next_pc_unit_if.slave  bus
);
    logic [PC_W-1:0] pc_p0;
    logic [PC_W-1:0] pc_plus2;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] ras_top;
    logic            flush;
    logic            ras_empty;
    logic            take_ret;

    function automatic logic [PC_W-1:0] resolve_target(
        input logic [1:0]               kind,
        input logic                     taken,
        input logic [PC_W-1:0]          pc2,
        input logic [PC_W-1:0]          imm,
        input logic [PC_W-1:0]          reg_tgt,
        input logic signed [DISP_W-1:0] disp
    );
        logic signed [PC_W-1:0] disp_ext;
        logic [PC_W-1:0]        result;
        disp_ext = PC_W'(disp);
        result   = pc2;
        case (ex_kind_e'(kind))
            KIND_BR:   result = taken ? pc2 + imm : pc2;
            KIND_JREL: result = pc2 + PC_W'(disp_ext);
            KIND_JREG: result = reg_tgt;
            default:   result = pc2;
        endcase
        return result;
    endfunction

    assign pc_plus2 = pc_p0 + PC_W'(2);
    assign target   = resolve_target(bus.ex_kind, bus.ex_taken, bus.ex_pc2,
                                     bus.ex_imm, bus.ex_reg, bus.ex_disp);
    assign flush    = bus.ex_valid && (target != bus.ex_pred);

`ifdef NEXT_PC_RAS_EN
    logic push;
    logic pop;
    logic unused_full;

    // A simultaneous call and return behaves as a call only.
    assign push     = bus.f_call && !flush && !bus.stall;
    assign pop      = bus.f_ret && !bus.f_call && !flush && !bus.stall && !ras_empty;
    assign take_ret = pop;

    ras_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_plus2),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (unused_full)
    );
`else
    logic unused_ras;

    assign unused_ras = ^{bus.f_call, bus.f_ret};
    assign ras_empty  = 1'b1;
    assign ras_top    = '0;
    assign take_ret   = 1'b0;
`endif

    always_comb begin
        pc_next = pc_plus2;
        if (flush) begin
            pc_next = target;
        end else if (bus.stall) begin
            pc_next = pc_p0;
        end else if (take_ret) begin
            pc_next = ras_top;
        end
    end

    // Fetch PC register boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_p0 <= PC_W'(RESET_PC);
        end else begin
            pc_p0 <= pc_next;
        end
    end

    assign bus.pc        = pc_p0;
    assign bus.pc_plus2  = pc_plus2;
    assign bus.flush     = flush;
    assign bus.ras_empty = ras_empty;
endmodule
